onehot_decoder_seq: RTL
=======================

Name: onehot_decoder_seq

Overview:
- Binary-to-one-hot sequencer, the decode counterpart of the team's 8-to-3 one-hot encoder.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Drives the decoded one-hot word for a programmable number of cycles per code.
- Feeds select/strobe lines in the datapath; a round trip through the encoder returns the original code.

Parameters:
- IN_W, 3, code width; OUT_W = 2**IN_W (8) is derived, not overridable.
- HOLD_CYCLES, 4, cycles each one-hot word is held on out; legal range 1..255.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of FIFO and FSM.
- in_code  in  IN_W  binary code to decode.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  FIFO can accept a code.
- out  out  OUT_W  registered one-hot word, 0 when idle.
- out_valid  out  1  out carries a decoded word.
- busy  out  1  FSM in HOLD or FIFO non-empty.
- level  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n low, async): out=0, out_valid=0, FIFO empty, level=0, state IDLE, hold counter 0. in_ready=1 once rst_n is high.
- Push: the FIFO captures in_code on an edge where in_valid & in_ready. in_ready = (level != DEPTH), combinational from registered level only.
- FSM IDLE:
  - out=0, out_valid=0.
  - If FIFO is non-empty, pop the head, load out = 1 << code, out_valid=1, counter = HOLD_CYCLES-1, go to HOLD.
- FSM HOLD:
  - If counter != 0, decrement; out is unchanged.
  - If counter == 0 and FIFO is non-empty, pop and load the next word back-to-back (no idle gap).
  - If counter == 0 and FIFO is empty, return to IDLE; out=0 on that edge.
- Latency and timing:
  - A code accepted at edge N while IDLE and FIFO empty appears on out at edge N+1.
  - Each word stays on out for exactly HOLD_CYCLES cycles.
  - HOLD_CYCLES=1 gives a new word every cycle.
- Simultaneous push and pop: legal when not full; level is unchanged. When full, in_ready=0, so a push is never coincident with full. A pop in that cycle raises in_ready the following cycle, not the same cycle.
- Decode rule: out has exactly one bit set whenever out_valid=1, and is all-zero otherwise. Every IN_W code is legal, so there is no default/error case.
- flush has priority over push and pop:
  - Next edge: FIFO empty, level=0, state IDLE, out=0, out_valid=0.
  - A push presented in the flush cycle is dropped.
- Async reset mid-HOLD: outputs go to their reset values immediately, with no partial word left on out.
- FIFO pointers wrap modulo DEPTH. level is a separate counter, not a pointer difference.
- busy = (state==HOLD) | (level!=0).

Optional Feature:
- Macro: DEC_PARITY_EN.
- Defined:
  - Adds ports in_par (in, 1: even parity over in_code) and par_err (out, 1).
  - A handshake with a parity mismatch is accepted (the handshake completes) but the code is not written to the FIFO.
  - par_err pulses high for one cycle on the edge after the accept. par_err resets to 0 and is cleared by flush.
- Undefined: no extra ports; every accepted code is pushed.

Test Plan:
- Reset release, single code 3'b101 accepted at edge 1 -> out=8'b0010_0000, out_valid=1 on edges 2..5 (HOLD_CYCLES=4); out=0, out_valid=0 at edge 6.
- Burst 0,7,3 with in_valid held high -> in_ready drops when level=2; out sequence 8'h01, 8'h80, 8'h08, each 4 cycles with no gap; busy falls one cycle after the last word ends.
- HOLD_CYCLES=1, all codes 0..7 streamed -> out walks 8'h01..8'h80 one per cycle; count outputs and check each is one-hot.
- flush asserted mid-HOLD with level=2 -> next edge out=0, out_valid=0, level=0, in_ready=1; a code pushed in the flush cycle never appears on out.
- rst_n pulsed low mid-HOLD -> out and out_valid go to 0 asynchronously before the next clk edge; after release, operation resumes from empty.
- DEC_PARITY_EN: code 3'b011 with in_par=1 -> par_err=1 for one cycle and out stays 0; with in_par=0 -> out=8'h08.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: queues IN_W-bit codes and drives each as a one-hot word on out for HOLD_CYCLES cycles.
// Latency: a code accepted at edge N while idle with an empty FIFO appears at edge N+1; queued words follow with no gap.
// Backpressure: in_ready = FIFO not full, taken from registered level. Optional DEC_PARITY_EN adds in_par/par_err.

// onehot_dec_fifo: generic circular FIFO with synchronous flush and a separate occupancy counter.
// Latency: pop_dat shows the head combinationally; a push is visible at the head one edge later.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module onehot_dec_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic [W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            if (push_vld && !pop_vld)      level <= level + 1'b1;
            else if (!push_vld && pop_vld) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module onehot_decoder_seq #(
    parameter  int IN_W        = 3,
    parameter  int HOLD_CYCLES = 4,
    parameter  int DEPTH       = 2,
    localparam int OUT_W       = 2 ** IN_W,
    localparam int LW          = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic [LW-1:0]    level
`ifdef DEC_PARITY_EN
    ,
    input  logic             in_par,
    output logic             par_err
`endif
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [OUT_W-1:0] out_nxt;
    logic             out_valid_nxt;
    logic             load;
    logic             pop_vld;
    logic             push_vld;
    logic             acc_vld;
    logic [IN_W-1:0]  head_dat;
    logic             fifo_empty;

    assign in_ready = (level != LW'(DEPTH));
    // A push in a flush cycle is discarded, so it never counts as accepted.
    assign acc_vld  = in_valid & in_ready & ~flush;

`ifdef DEC_PARITY_EN
    logic par_ok;
    assign par_ok   = (in_par == ^in_code);
    assign push_vld = acc_vld & par_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err <= 1'b0;
        else        par_err <= acc_vld & ~par_ok;
    end
`else
    assign push_vld = acc_vld;
`endif

    onehot_dec_fifo #(.W(IN_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push_vld (push_vld),
        .push_dat (in_code),
        .pop_vld  (pop_vld),
        .pop_dat  (head_dat),
        .level    (level)
    );

    assign fifo_empty = (level == '0);
    assign busy       = (state == HOLD) | ~fifo_empty;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        out_nxt       = out;
        out_valid_nxt = out_valid;
        load          = 1'b0;
        pop_vld       = 1'b0;
        if (flush) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            out_nxt       = '0;
            out_valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_nxt       = '0;
                    out_valid_nxt = 1'b0;
                    if (!fifo_empty) load = 1'b1;
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_nxt     = IDLE;
                        out_nxt       = '0;
                        out_valid_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        // Loading from HOLD with cnt==0 chains words without an idle cycle.
        if (load) begin
            pop_vld       = 1'b1;
            state_nxt     = HOLD;
            cnt_nxt       = 8'(HOLD_CYCLES - 1);
            out_nxt       = OUT_W'(1) << head_dat;
            out_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
        end
    end
endmodule
